stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_btn_conditioner.sv | 56 +++++
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control front-end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ_DEF  = 50_000_000;
  localparam int unsigned TICK_HZ_DEF = 100;

  // Clock cycles per counter-chain tick.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// Button conditioner: synchronizer, debouncer and one-cycle press pulse on
// the debounced rising edge.
module btn_conditioner #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned    CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;
  logic                   r_db_d;
  logic                   r_armed;
  logic                   r_press;
  logic                   w_sync;
  logic                   w_diff;

  assign w_sync = r_sync[SYNC_STAGES-1];
  // Until a released level has been debounced, a low input also counts as a
  // change, so a button held through reset never produces a press.
  assign w_diff = (w_sync != r_db) || (!r_armed && !w_sync);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d & r_armed;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_db  <= w_sync;
        if (!w_sync) r_armed <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button conditioning, IDLE/RUN/PAUSE FSM,
// time-base tick and clear pulse. Lap toggle enabled by STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ     = TICK_HZ_DEF,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ss,
  input  logic btn_clr,
  output logic tick,
  output logic clr_n,
  output logic running,
  output logic paused,
  output logic lap
);

  localparam int unsigned   DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned   PW      = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic          w_ss;
  logic          w_clr;
  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic          r_clr_n;
  logic          r_running;
  logic          r_paused;
`ifdef STOPWATCH_LAP_EN
  logic          r_lap;
`endif

  btn_conditioner #(
    .DB_CYCLES  (DB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_ss (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_ss),
    .o_press(w_ss)
  );

  btn_conditioner #(
    .DB_CYCLES  (DB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_clr (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_clr),
    .o_press(w_clr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_tick    <= 1'b0;
      r_clr_n   <= 1'b1;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap     <= 1'b0;
`endif
    end else begin
      r_tick  <= 1'b0;
      r_clr_n <= 1'b1;
      case (r_state)
        IDLE: begin
          r_pre <= '0;
          if (w_clr) begin
            r_clr_n <= 1'b0;
          end else if (w_ss) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          // ss wins over clr; leaving RUN neither advances nor ticks.
          if (w_ss) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
            r_paused  <= 1'b1;
          end else begin
            if (r_pre == PRE_MAX) begin
              r_pre  <= '0;
              r_tick <= 1'b1;
            end else begin
              r_pre <= r_pre + 1'b1;
            end
`ifdef STOPWATCH_LAP_EN
            if (w_clr) r_lap <= ~r_lap;
`endif
          end
        end
        PAUSE: begin
          if (w_clr) begin
            r_state  <= IDLE;
            r_paused <= 1'b0;
            r_pre    <= '0;
            r_clr_n  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            r_lap    <= 1'b0;
`endif
          end else if (w_ss) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_paused  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pre     <= '0;
          r_running <= 1'b0;
          r_paused  <= 1'b0;
        end
      endcase
    end
  end

  assign tick    = r_tick;
  assign clr_n   = r_clr_n;
  assign running = r_running;
  assign paused  = r_paused;
`ifdef STOPWATCH_LAP_EN
  assign lap     = r_lap;
`else
  assign lap     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (DIV=10, DB_CYCLES=4, SYNC_STAGES=2).
module tb_stopwatch_ctrl;

  logic clk;
  logic rst;
  logic btn_ss;
  logic btn_clr;
  logic tick;
  logic clr_n;
  logic running;
  logic paused;
  logic lap;

  int total;
  int bad;
  int pre_m;
  logic exp_lap;

  stopwatch_ctrl #(
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .DB_CYCLES  (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_ss (btn_ss),
    .btn_clr(btn_clr),
    .tick   (tick),
    .clr_n  (clr_n),
    .running(running),
    .paused (paused),
    .lap    (lap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // n cycles with fixed state expectation; cnt marks cycles where the
  // prescaler advances, and the tick expectation follows from it.
  task automatic chk_span(input int n, input logic er, input logic ep, input logic cnt);
    logic et;
    for (int i = 0; i < n; i++) begin
      et = cnt && (pre_m == 9);
      if (cnt) pre_m = (pre_m == 9) ? 0 : pre_m + 1;
      @(posedge clk); #1;
      chk("tick", tick, et);
      chk("clr_n", clr_n, 1'b1);
      chk("running", running, er);
      chk("paused", paused, ep);
      chk("lap", lap, exp_lap);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"}, tick, 1'b0);
    chk({tag, "_clr_n"}, clr_n, 1'b1);
    chk({tag, "_running"}, running, 1'b0);
    chk({tag, "_paused"}, paused, 1'b0);
    chk({tag, "_lap"}, lap, 1'b0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    pre_m   = 0;
    exp_lap = 1'b0;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    rst     = 1'b1;
    #2 rst  = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Idle after reset
    chk_span(50, 1'b0, 1'b0, 1'b0);

    // Start: running 8 cycles after raw edge, first tick 10 cycles later
    btn_ss = 1'b1;
    chk_span(7, 1'b0, 1'b0, 1'b0);
    chk_span(1, 1'b1, 1'b0, 1'b0);
    chk_span(2, 1'b1, 1'b0, 1'b1);
    btn_ss = 1'b0;
    chk_span(30, 1'b1, 1'b0, 1'b1);

    // 3-cycle glitch is rejected
    btn_ss = 1'b1;
    chk_span(3, 1'b1, 1'b0, 1'b1);
    btn_ss = 1'b0;
    chk_span(15, 1'b1, 1'b0, 1'b1);

    // Pause with the prescaler at 6 on the transition cycle
    while (pre_m != 9) chk_span(1, 1'b1, 1'b0, 1'b1);
    btn_ss = 1'b1;
    chk_span(7, 1'b1, 1'b0, 1'b1);
    chk_span(1, 1'b0, 1'b1, 1'b0);
    btn_ss = 1'b0;
    chk_span(20, 1'b0, 1'b1, 1'b0);

    // Resume: next tick exactly 4 cycles after running rises
    btn_ss = 1'b1;
    chk_span(7, 1'b0, 1'b1, 1'b0);
    chk_span(1, 1'b1, 1'b0, 1'b0);
    btn_ss = 1'b0;
    chk_span(4, 1'b1, 1'b0, 1'b1);
    chk_span(10, 1'b1, 1'b0, 1'b1);

    // clr presses in RUN: lap toggles only with the feature built in
    for (int k = 0; k < 3; k++) begin
      btn_clr = 1'b1;
      chk_span(7, 1'b1, 1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
      exp_lap = ~exp_lap;
`endif
      chk_span(1, 1'b1, 1'b0, 1'b1);
      btn_clr = 1'b0;
      chk_span(12, 1'b1, 1'b0, 1'b1);
    end

    // Pause keeps lap
    btn_ss = 1'b1;
    chk_span(7, 1'b1, 1'b0, 1'b1);
    chk_span(1, 1'b0, 1'b1, 1'b0);
    btn_ss = 1'b0;
    chk_span(12, 1'b0, 1'b1, 1'b0);

    // Simultaneous ss+clr in PAUSE: clear wins, back to IDLE
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    chk_span(7, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("both_tick", tick, 1'b0);
    chk("both_clr_n", clr_n, 1'b0);
    chk("both_running", running, 1'b0);
    chk("both_paused", paused, 1'b0);
    chk("both_lap", lap, 1'b0);
    exp_lap = 1'b0;
    pre_m   = 0;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    chk_span(20, 1'b0, 1'b0, 1'b0);

    // Restart proves the prescaler was cleared: first tick 10 cycles after run
    btn_ss = 1'b1;
    chk_span(7, 1'b0, 1'b0, 1'b0);
    chk_span(1, 1'b1, 1'b0, 1'b0);
    btn_ss = 1'b0;
    while (pre_m != 5) chk_span(1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN, button held across release
    #2 rst = 1'b0;
    #1 chk_reset_vals("midrun_rst");
    btn_ss = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    pre_m   = 0;
    exp_lap = 1'b0;
    chk_span(30, 1'b0, 1'b0, 1'b0);
    btn_ss = 1'b0;
    chk_span(12, 1'b0, 1'b0, 1'b0);
    btn_ss = 1'b1;
    chk_span(7, 1'b0, 1'b0, 1'b0);
    chk_span(1, 1'b1, 1'b0, 1'b0);
    btn_ss = 1'b0;
    chk_span(12, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
